aes_job_driver: RTL and testbench

- Host-side initiator for the AESTOP core. It accepts encrypt/decrypt jobs (mode, key, block) on a valid/ready interface and issues each one to AESTOP with a one-cycle start pulse.
- It waits for AESTOP completion, then queues the result in a small FIFO for a valid/ready consumer.
- Adds a completion timeout, a sticky error flag and a job counter, so the core can sit behind a streaming datapath without the sequencing being done in a testbench.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_result_fifo.sv | 60 ++++++
 rtl/aes_job_driver.sv | 152 +++++++++++++++
 tb/tb_aes_job_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES job driver slice.
//   AES_BLK_W          : width of key / data blocks
//   MODE_ENC/MODE_DEC  : job mode encodings
//   state_e            : job sequencer states
//   res_t              : one result FIFO entry {mode, cipher output}
package aes_pkg;
    localparam int AES_BLK_W = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                 mode;
        logic [AES_BLK_W-1:0] data;
    } res_t;
endpackage

// File: rtl/aes_result_fifo.sv
// Synchronous FIFO with an occupancy count; the head entry is read
// straight out of storage, so it is always a registered value.
//   clk, rst_n : clock, asynchronous active-low reset (discards contents)
//   i_push     : write i_data (ignored when full with no pop)
//   i_pop      : drop head (ignored when empty)
//   o_data     : head entry
//   o_count    : number of stored entries, 0..DEPTH
module aes_result_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    always_comb begin
        do_pop   = i_pop & (count_q != '0);
        do_push  = i_push & ((count_q != CW'(DEPTH)) | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;
endmodule

// File: rtl/aes_job_driver.sv
// Host-side initiator for the AESTOP core. Takes jobs on a valid/accept
// interface, issues each with a one-cycle start pulse, waits for a rising
// edge of the core's ready, and queues {mode, result} for the consumer.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_valid/o_accept, i_mode/i_key/i_data : job input
//   o_aes_start/mode/key/in         : to AESTOP
//   i_aes_cipher, i_aes_ready       : from AESTOP
//   o_valid/i_ready, o_result/o_result_mode : result output (FIFO head)
//   o_busy    : a job is in flight
//   o_timeout : sticky abandoned-job flag, cleared by i_clr_err
//   o_job_cnt : completed jobs, wrapping
module aes_job_driver
    import aes_pkg::*;
#(
    parameter int RES_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_accept,
    input  logic                 i_mode,
    input  logic [127:0]         i_key,
    input  logic [127:0]         i_data,
    output logic                 o_aes_start,
    output logic                 o_aes_mode,
    output logic [127:0]         o_aes_key,
    output logic [127:0]         o_aes_in,
    input  logic [127:0]         i_aes_cipher,
    input  logic                 i_aes_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [127:0]         o_result,
    output logic                 o_result_mode,
    output logic                 o_busy,
    output logic                 o_timeout,
    input  logic                 i_clr_err,
    output logic [CNT_W-1:0]     o_job_cnt
);
    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [AES_BLK_W-1:0] key_q, key_d, data_q, data_d;
    logic                 ready_q, ready_d;
    logic [TW-1:0]        wcnt_q, wcnt_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     job_cnt_q, job_cnt_d;
    // Low for the first cycle after reset so o_accept also reads 0 in reset.
    logic                 act_q, act_d;

    logic [CW-1:0]        fifo_cnt;
    res_t                 push_ent, head_ent;
    logic                 take, done, tmo;

    assign o_accept = act_q & (state_q == IDLE) & (fifo_cnt < CW'(RES_DEPTH));
    assign take     = i_valid & o_accept;
    // Edge detect: a level ready left over from the previous job is ignored.
    assign done     = (state_q == WAIT) & i_aes_ready & ~ready_q;
    assign tmo      = (state_q == WAIT) & ~done & (wcnt_q == TW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (done | tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_aes_start = (state_q == START);
        o_busy      = (state_q != IDLE);
    end

    // Job registers, wait counter, error flag, job counter
    always_comb begin
        mode_d    = mode_q;
        key_d     = key_q;
        data_d    = data_q;
        if (take) begin
            mode_d = i_mode;
            key_d  = i_key;
            data_d = i_data;
        end
        ready_d   = i_aes_ready;
        act_d     = 1'b1;
        wcnt_d    = wcnt_q;
        if (state_q == START)     wcnt_d = '0;
        else if (state_q == WAIT) wcnt_d = wcnt_q + 1'b1;
        timeout_d = tmo | (timeout_q & ~i_clr_err);
        job_cnt_d = job_cnt_q + CNT_W'(done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            key_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            act_q     <= 1'b0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            key_q     <= key_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            act_q     <= act_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    assign push_ent.mode = mode_q;
    assign push_ent.data = i_aes_cipher;

    aes_result_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (done),
        .i_data  (push_ent),
        .i_pop   (o_valid & i_ready),
        .o_data  (head_ent),
        .o_count (fifo_cnt)
    );

    assign o_valid       = (fifo_cnt != '0);
    assign o_result      = head_ent.data;
    assign o_result_mode = head_ent.mode;
    assign o_aes_mode    = mode_q;
    assign o_aes_key     = key_q;
    assign o_aes_in      = data_q;
    assign o_timeout     = timeout_q;
    assign o_job_cnt     = job_cnt_q;
endmodule

// File: tb/tb_aes_job_driver.sv
module tb_aes_job_driver;
    import aes_pkg::*;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid, i_mode, i_ready, i_clr_err;
    logic [127:0] i_key, i_data;
    logic         o_accept, o_aes_start, o_aes_mode, o_valid, o_result_mode;
    logic         o_busy, o_timeout;
    logic [127:0] o_aes_key, o_aes_in, o_result;
    logic [15:0]  o_job_cnt;
    logic         aes_ready;
    logic [127:0] aes_cipher;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    aes_job_driver #(.RES_DEPTH(4), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_accept(o_accept), .i_mode(i_mode), .i_key(i_key), .i_data(i_data),
        .o_aes_start(o_aes_start), .o_aes_mode(o_aes_mode), .o_aes_key(o_aes_key), .o_aes_in(o_aes_in),
        .i_aes_cipher(aes_cipher), .i_aes_ready(aes_ready),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_result_mode(o_result_mode),
        .o_busy(o_busy), .o_timeout(o_timeout), .i_clr_err(i_clr_err), .o_job_cnt(o_job_cnt)
    );

    // Behavioural AES core: knows the FIPS-197 vector, otherwise a simple mix.
    function automatic logic [127:0] aes_model(input logic m, input logic [127:0] k, input logic [127:0] d);
        if (!m && k == KEY && d == PT) return CT;
        if (m && k == KEY && d == CT)  return PT;
        return d ^ {k[63:0], k[127:64]} ^ {128{m}};
    endfunction

    // stub_cfg: 0 = ready pulse 3 cycles after start, 1 = never ready, 2 = ready follows stub_lvl
    int           stub_cfg = 0;
    logic         stub_lvl = 1'b0;
    logic         pend;
    int           lat;
    logic         s_mode;
    logic [127:0] s_key, s_in;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aes_ready  <= 1'b0;
            aes_cipher <= '0;
            pend       <= 1'b0;
            lat        <= 0;
        end else if (stub_cfg == 2) begin
            aes_ready  <= stub_lvl;
            aes_cipher <= aes_model(o_aes_mode, o_aes_key, o_aes_in);
        end else begin
            aes_ready <= 1'b0;
            if (o_aes_start) begin
                pend   <= (stub_cfg == 0);
                lat    <= 3;
                s_mode <= o_aes_mode;
                s_key  <= o_aes_key;
                s_in   <= o_aes_in;
            end else if (pend) begin
                if (lat == 1) begin
                    aes_ready  <= 1'b1;
                    aes_cipher <= aes_model(s_mode, s_key, s_in);
                    pend       <= 1'b0;
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    always @(negedge clk) if (o_aes_start) n_start++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic m, input logic [127:0] k, input logic [127:0] d,
                        input int budget, output bit ok);
        i_valid = 1'b1; i_mode = m; i_key = k; i_data = d; ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (o_accept) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!o_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop_chk(input string tag, input logic [127:0] exp_d, input logic exp_m);
        chk({tag, "_valid"}, o_valid, 1'b1);
        chk({tag, "_data"}, o_result, exp_d);
        chk({tag, "_mode"}, o_result_mode, exp_m);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int cyc, acc, s0;
        logic [127:0] d;

        rst_n = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_key = '0; i_data = '0;
        i_ready = 1'b0; i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_accept", o_accept, 1'b0);
        chk("rst_start", o_aes_start, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_timeout", o_timeout, 1'b0);
        chk("rst_jobcnt", o_job_cnt, 16'd0);
        chk("rst_result", o_result, 128'd0);
        chk("rst_aeskey", o_aes_key, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single encrypt
        s0 = n_start;
        send(MODE_ENC, KEY, PT, 10, ok);
        chk("enc_acc", ok, 1'b1);
        chk("enc_start", o_aes_start, 1'b1);
        chk("enc_aeskey", o_aes_key, KEY);
        chk("enc_aesin", o_aes_in, PT);
        wait_valid(20, cyc);
        chk("enc_latency", cyc, 5);
        chk("enc_nstart", n_start - s0, 1);
        chk("enc_busy", o_busy, 1'b0);
        chk("enc_jobcnt", o_job_cnt, 16'd1);
        pop_chk("enc", CT, MODE_ENC);

        // Decrypt
        send(MODE_DEC, KEY, CT, 10, ok);
        chk("dec_acc", ok, 1'b1);
        wait_valid(20, cyc);
        chk("dec_jobcnt", o_job_cnt, 16'd2);
        pop_chk("dec", PT, MODE_DEC);
        chk("dec_empty", o_valid, 1'b0);

        // Backpressure: 6 jobs offered, only 4 fit
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            d = PT + 128'(j);
            send(j[0], KEY, d, (acc < 4) ? 12 : 30, ok);
            if (ok) acc++;
        end
        chk("bp_accepted", acc, 4);
        chk("bp_accept_low", o_accept, 1'b0);
        chk("bp_busy", o_busy, 1'b0);
        chk("bp_jobcnt", o_job_cnt, 16'd6);
        i_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            d = PT + 128'(j);
            pop_chk($sformatf("bp_pop%0d", j), aes_model(j[0], KEY, d), j[0]);
        end
        chk("bp_drained", o_valid, 1'b0);
        for (int j = 4; j < 6; j++) begin
            d = PT + 128'(j);
            send(j[0], KEY, d, 10, ok);
            chk($sformatf("bp_late_acc%0d", j), ok, 1'b1);
            wait_valid(20, cyc);
            pop_chk($sformatf("bp_pop%0d", j), aes_model(j[0], KEY, d), j[0]);
        end
        chk("bp_jobcnt_end", o_job_cnt, 16'd8);

        // Timeout: core never answers
        stub_cfg = 1;
        send(MODE_ENC, KEY, PT, 10, ok);
        chk("to_acc", ok, 1'b1);
        repeat (64) @(negedge clk);
        chk("to_not_yet", o_timeout, 1'b0);
        chk("to_busy_still", o_busy, 1'b1);
        @(negedge clk);
        chk("to_flag", o_timeout, 1'b1);
        chk("to_idle", o_busy, 1'b0);
        chk("to_nowrite", o_valid, 1'b0);
        chk("to_jobcnt", o_job_cnt, 16'd8);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        chk("to_clr", o_timeout, 1'b0);

        // Stale ready: level high before the job starts
        stub_cfg = 2;
        stub_lvl = 1'b1;
        repeat (2) @(negedge clk);
        d = 128'hdeadbeef_00000000_cafef00d_12345678;
        send(MODE_DEC, KEY, d, 10, ok);
        chk("st_acc", ok, 1'b1);
        repeat (10) @(negedge clk);
        chk("st_nodone", o_valid, 1'b0);
        chk("st_busy", o_busy, 1'b1);
        stub_lvl = 1'b0;
        repeat (2) @(negedge clk);
        stub_lvl = 1'b1;
        wait_valid(10, cyc);
        chk("st_jobcnt", o_job_cnt, 16'd9);
        pop_chk("st", aes_model(MODE_DEC, KEY, d), MODE_DEC);
        repeat (4) @(negedge clk);
        chk("st_onewrite", o_valid, 1'b0);
        chk("st_idle", o_busy, 1'b0);
        stub_lvl = 1'b0;
        stub_cfg = 0;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT with a result already queued
        send(MODE_ENC, KEY, PT, 10, ok);
        wait_valid(20, cyc);
        chk("rs_queued", o_valid, 1'b1);
        send(MODE_DEC, KEY, CT, 10, ok);
        chk("rs_acc", ok, 1'b1);
        @(negedge clk);
        chk("rs_inwait", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_start", o_aes_start, 1'b0);
        chk("rs_valid", o_valid, 1'b0);
        chk("rs_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rs_empty", o_valid, 1'b0);
        chk("rs_jobcnt", o_job_cnt, 16'd0);
        chk("rs_accept", o_accept, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
